// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared widths, FSM state type and core timing constant for the sqrt dispatcher
package sqrt_pkg;
  localparam int RADICAND_W = 32;
  localparam int ROOT_W = 16;
  localparam int CORE_LATENCY = 17;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} sqrt_dispatch_state_t;
endpackage

// File: rtl/sqrt_dispatch_fifo.sv
// sqrt_dispatch_fifo: synchronous request FIFO with extra-bit pointers for wrap-safe full/empty
module sqrt_dispatch_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, rd_q;
  logic [W-1:0] mem_q [DEPTH];
  assign full_o = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
  assign empty_o = wr_q == rd_q;
  assign head_o = mem_q[rd_q[AW-1:0]];
  // pointer advance; a full FIFO refuses pushes even when popping the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i && !full_o) wr_q <= wr_q + 1'b1;
      if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
    end
  end
  // storage needs no reset: empty pointers make stale entries unreachable
  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/sqrt_dispatch.sv
// sqrt_dispatch: FIFO-buffered request front-end for the iterative sqrt core; SQRT_DISPATCH_BYPASS_EN short-circuits radicands 0 and 1
module sqrt_dispatch
  import sqrt_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [RADICAND_W-1:0] in_radicand,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  core_start,
  output logic [RADICAND_W-1:0] core_radicand,
  input  logic                  core_busy,
  input  logic                  core_done,
  input  logic [RADICAND_W-1:0] core_root,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ROOT_W-1:0]     out_root,
  output logic [TAG_W-1:0]      out_tag
);
  localparam int W = RADICAND_W + TAG_W;
  sqrt_dispatch_state_t state_q, state_d;
  logic fifo_full, fifo_empty, issue, byp, pop, done_hit;
  logic [W-1:0] head;
  logic [RADICAND_W-1:0] head_rad;
  logic [TAG_W-1:0] head_tag;
  logic core_start_q, core_start_d, out_valid_q, out_valid_d;
  logic [RADICAND_W-1:0] core_radicand_q, core_radicand_d;
  logic [ROOT_W-1:0] out_root_q, out_root_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic unused_root;
  sqrt_dispatch_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (in_valid && in_ready),
    .pop_i  (pop),
    .data_i ({in_tag, in_radicand}),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .head_o (head)
  );
  assign {head_tag, head_rad} = head;
  assign in_ready = !fifo_full;
`ifdef SQRT_DISPATCH_BYPASS_EN
  assign byp = state_q == IDLE && !fifo_empty && !out_valid_q && head_rad[RADICAND_W-1:1] == '0;
`else
  assign byp = 1'b0;
`endif
  assign issue = state_q == IDLE && !fifo_empty && !core_busy && !out_valid_q && !byp;
  assign pop = issue || byp;
  assign done_hit = state_q == WAIT && core_done;
  assign unused_root = ^core_root[RADICAND_W-1:ROOT_W];
  assign core_start = core_start_q;
  assign core_radicand = core_radicand_q;
  assign out_valid = out_valid_q;
  assign out_root = out_root_q;
  assign out_tag = out_tag_q;
  // state and output registers; reset discards any in-flight operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      core_start_q    <= 1'b0;
      core_radicand_q <= '0;
      out_valid_q     <= 1'b0;
      out_root_q      <= '0;
      out_tag_q       <= '0;
    end else begin
      state_q         <= state_d;
      core_start_q    <= core_start_d;
      core_radicand_q <= core_radicand_d;
      out_valid_q     <= out_valid_d;
      out_root_q      <= out_root_d;
      out_tag_q       <= out_tag_d;
    end
  end
  // one operation in flight: issue, wait for the core, hold until the consumer takes it
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = byp ? HOLD : issue ? ISSUE : IDLE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = core_done ? HOLD : WAIT;
      HOLD:    state_d = out_ready ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  // registered outputs: start pulse on issue, result captured on done or bypass
  always_comb begin
    core_start_d    = issue;
    core_radicand_d = issue ? head_rad : core_radicand_q;
    out_tag_d       = pop ? head_tag : out_tag_q;
    out_root_d      = done_hit ? core_root[ROOT_W-1:0] : byp ? ROOT_W'(head_rad[0]) : out_root_q;
    out_valid_d     = done_hit || byp || (out_valid_q && !out_ready);
  end
endmodule

// File: tb/tb_sqrt_dispatch.sv
// tb_sqrt_dispatch: directed bench for sqrt_dispatch with a behavioural 17-cycle sqrt core
module tb_sqrt_dispatch;
  import sqrt_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid, in_ready, core_start, core_busy = 1'b0, core_done = 1'b0;
  logic out_valid, out_ready;
  logic [31:0] in_radicand, core_radicand, core_root = '0, opnd = '0;
  logic [3:0] in_tag, out_tag;
  logic [15:0] out_root;
  int cnt = 0, starts = 0, total = 0, bad = 0;
  logic [31:0] rads [6] = '{32'd16, 32'd25, 32'd36, 32'd49, 32'd64, 32'd100};
  logic [15:0] roots [6] = '{16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd10};

  always #5 clk = ~clk;

  sqrt_dispatch #(.DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_radicand(in_radicand), .in_tag(in_tag),
    .core_start(core_start), .core_radicand(core_radicand), .core_busy(core_busy),
    .core_done(core_done), .core_root(core_root),
    .out_valid(out_valid), .out_ready(out_ready), .out_root(out_root), .out_tag(out_tag)
  );

  function automatic logic [31:0] isqrt(input logic [31:0] x);
    logic [31:0] r;
    logic [63:0] t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = 64'(r | (32'd1 << b));
      if (t * t <= 64'(x)) r = r | (32'd1 << b);
    end
    return r;
  endfunction

  // core stand-in: done pulses in the 17th cycle after the start cycle
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_busy <= 1'b0; core_done <= 1'b0; cnt <= 0; core_root <= '0;
    end else if (core_start) begin
      core_busy <= 1'b1; core_done <= 1'b0; cnt <= CORE_LATENCY - 1; opnd <= core_radicand;
    end else begin
      core_done <= 1'b0;
      if (cnt == 1) begin core_done <= 1'b1; core_root <= isqrt(opnd); end
      if (cnt > 0) cnt <= cnt - 1;
      if (core_done) core_busy <= 1'b0;
    end
  end

  always @(posedge clk) if (core_start) starts <= starts + 1;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", nm, obs, exp_v);
    end
  endtask

  task automatic push(input logic [31:0] r, input logic [3:0] t);
    int k;
    k = 0;
    in_radicand = r; in_tag = t; in_valid = 1'b1;
    while (!in_ready && k < 200) begin step(); k++; end
    chk("push_ready", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic take(input string nm, input logic [15:0] er, input logic [3:0] et, input int elat);
    int n;
    n = 1;
    while (!out_valid && n < 300) begin step(); n++; end
    chk({nm, "_valid"}, 32'(out_valid), 1);
    if (elat != 0) chk({nm, "_lat"}, n, elat);
    chk({nm, "_root"}, 32'(out_root), 32'(er));
    chk({nm, "_tag"}, 32'(out_tag), 32'(et));
    step();
  endtask

  initial begin
    int n, s0;
    logic stable, quiet;
    logic [15:0] hr;
    logic [3:0] ht;
    in_valid = 1'b0; in_radicand = '0; in_tag = '0; out_ready = 1'b1;
    step(); step();
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_core_start", 32'(core_start), 0);
    chk("rst_core_radicand", core_radicand, 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_root", 32'(out_root), 0);
    chk("rst_out_tag", 32'(out_tag), 0);
    rst = 1'b0;
    step();
    push(32'd144, 4'd3);
    take("basic", 16'd12, 4'd3, 20);
    chk("basic_consumed", 32'(out_valid), 0);
    push(32'hFFFF_FFFF, 4'd5);
    push(32'd2, 4'd6);
    take("max", 16'hFFFF, 4'd5, 0);
    take("two", 16'd1, 4'd6, 0);
`ifdef SQRT_DISPATCH_BYPASS_EN
    s0 = starts;
    push(32'd0, 4'd7);
    take("byp0", 16'd0, 4'd7, 2);
    push(32'd1, 4'd8);
    take("byp1", 16'd1, 4'd8, 2);
    chk("byp_no_start", starts, s0);
`else
    push(32'd0, 4'd7);
    take("zero", 16'd0, 4'd7, 20);
`endif
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(rads[i], 4'(8 + i));
    chk("full_in_ready", 32'(in_ready), 0);
    in_radicand = rads[5]; in_tag = 4'd13; in_valid = 1'b1;
    n = 0;
    while (!out_valid && n < 300) begin step(); n++; end
    chk("full0_valid", 32'(out_valid), 1);
    chk("full0_root", 32'(out_root), 32'(roots[0]));
    chk("full0_tag", 32'(out_tag), 8);
    s0 = starts; hr = out_root; ht = out_tag; stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (out_root !== hr || out_tag !== ht || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    chk("bp_stable", 32'(stable), 1);
    chk("bp_no_start", starts, s0);
    out_ready = 1'b1;
    step();
    chk("rel_c1_start", 32'(core_start), 0);
    chk("rel_c1_valid", 32'(out_valid), 0);
    step();
    chk("rel_c2_start", 32'(core_start), 1);
    chk("rel_in_ready", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    for (int i = 1; i < 6; i++) take("full", roots[i], 4'(8 + i), 0);
    push(32'd400, 4'd2);
    push(32'd9, 4'd4);
    for (int i = 0; i < 8; i++) step();
    rst = 1'b1;
    #1;
    chk("mid_in_ready", 32'(in_ready), 1);
    chk("mid_core_start", 32'(core_start), 0);
    chk("mid_core_radicand", core_radicand, 0);
    chk("mid_out_valid", 32'(out_valid), 0);
    chk("mid_out_root", 32'(out_root), 0);
    chk("mid_out_tag", 32'(out_tag), 0);
    step(); step();
    rst = 1'b0;
    s0 = starts; quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid !== 1'b0 || core_start !== 1'b0) quiet = 1'b0;
    end
    chk("post_rst_quiet", 32'(quiet), 1);
    chk("post_rst_no_start", starts, s0);
    push(32'd81, 4'd1);
    take("after_rst", 16'd9, 4'd1, 20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
